// File: rtl/pdm_rcvr.sv
// pdm_rcvr - stereo PDM receiver / decimator.
//
// Takes left and right 1-bit PDM streams, which may be asynchronous to clk.
// Each stream is counted over a boxcar window of W = 2^DECIM_LOG2 clocks.
// The ones-count becomes a 16-bit signed PCM sample, in the same format the
// EQ engine feeds to spkr_drv.
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   en          receiver enable (level)
//   lft_PDM     left PDM bit stream (asynchronous)
//   rght_PDM    right PDM bit stream (asynchronous)
//   vld         one-cycle strobe, new samples on lft_chnnl / rght_chnnl
//   lft_chnnl   signed left PCM sample, held between strobes
//   rght_chnnl  signed right PCM sample, held between strobes
//   busy        FSM is in WARMUP or RUN
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | counters cleared, waiting for en
// WARMUP | one discarded window; flushes the synchronizers and stale data
// RUN    | back-to-back windows, vld at every window end
module pdm_rcvr #(
  parameter int DECIM_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        lft_PDM,
  input  logic        rght_PDM,
  output logic        vld,
  output logic [15:0] lft_chnnl,
  output logic [15:0] rght_chnnl,
  output logic        busy
);

  localparam int AW = DECIM_LOG2 + 1;
  localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;
  localparam logic [AW-1:0]         ACC_FULL = {1'b1, {DECIM_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

  state_t                state, state_nxt;
  logic [DECIM_LOG2-1:0] win_cnt, win_cnt_nxt;
  logic [AW-1:0]         acc_l, acc_l_nxt, acc_r, acc_r_nxt;
  logic [AW-1:0]         sum_l, sum_r;
  logic [15:0]           lft_nxt, rght_nxt;
  logic                  vld_nxt;
  logic                  lft_s1, lft_s, rght_s1, rght_s;

  // A full window of ones cannot be represented by the shift alone, so it
  // saturates to full scale. The MSB flip turns offset-binary into signed.
  function automatic logic [15:0] conv(input logic [AW-1:0] k);
    logic [15:0] u;
    if (k == ACC_FULL) u = 16'hFFFF;
    else               u = 16'(k) << (16 - DECIM_LOG2);
    return u ^ 16'h8000;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      lft_s1     <= 1'b0;
      lft_s      <= 1'b0;
      rght_s1    <= 1'b0;
      rght_s     <= 1'b0;
      state      <= IDLE;
      win_cnt    <= '0;
      acc_l      <= '0;
      acc_r      <= '0;
      lft_chnnl  <= 16'h0000;
      rght_chnnl <= 16'h0000;
      vld        <= 1'b0;
    end else begin
      lft_s1     <= lft_PDM;
      lft_s      <= lft_s1;
      rght_s1    <= rght_PDM;
      rght_s     <= rght_s1;
      state      <= state_nxt;
      win_cnt    <= win_cnt_nxt;
      acc_l      <= acc_l_nxt;
      acc_r      <= acc_r_nxt;
      lft_chnnl  <= lft_nxt;
      rght_chnnl <= rght_nxt;
      vld        <= vld_nxt;
    end
  end

  // Window-end sums include the current synchronized bit so the last clock
  // of the window is not lost when the accumulators clear.
  assign sum_l = acc_l + {{DECIM_LOG2{1'b0}}, lft_s};
  assign sum_r = acc_r + {{DECIM_LOG2{1'b0}}, rght_s};

  always_comb begin
    state_nxt   = state;
    win_cnt_nxt = win_cnt;
    acc_l_nxt   = acc_l;
    acc_r_nxt   = acc_r;
    lft_nxt     = lft_chnnl;
    rght_nxt    = rght_chnnl;
    vld_nxt     = 1'b0;
    case (state)
      IDLE: begin
        win_cnt_nxt = '0;
        acc_l_nxt   = '0;
        acc_r_nxt   = '0;
        if (en) state_nxt = WARMUP;
      end
      WARMUP, RUN: begin
        if (!en) begin
          state_nxt   = IDLE;
          win_cnt_nxt = '0;
          acc_l_nxt   = '0;
          acc_r_nxt   = '0;
        end else if (win_cnt == CNT_LAST) begin
          state_nxt   = RUN;
          win_cnt_nxt = '0;
          acc_l_nxt   = '0;
          acc_r_nxt   = '0;
          if (state == RUN) begin
            vld_nxt  = 1'b1;
            lft_nxt  = conv(sum_l);
            rght_nxt = conv(sum_r);
          end
        end else begin
          win_cnt_nxt = win_cnt + 1'b1;
          acc_l_nxt   = sum_l;
          acc_r_nxt   = sum_r;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_pdm_rcvr.sv
// Bench for pdm_rcvr with DECIM_LOG2 = 4 (W = 16).
// The reference model tracks only "active since edge e0" and recomputes each
// expected sample by summing the recorded pin history over the window.
module tb_pdm_rcvr;
  localparam int DL   = 4;
  localparam int W    = 16;
  localparam int MAXC = 8192;

  logic        clk = 1'b0;
  logic        rst, en, lft_PDM, rght_PDM;
  logic        vld, busy;
  logic [15:0] lft_chnnl, rght_chnnl;

  pdm_rcvr #(.DECIM_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .en(en), .lft_PDM(lft_PDM), .rght_PDM(rght_PDM),
    .vld(vld), .lft_chnnl(lft_chnnl), .rght_chnnl(rght_chnnl), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic pin_l [MAXC];
  logic pin_r [MAXC];

  bit          m_active = 1'b0;
  int          m_e0 = 0;
  logic        m_vld = 1'b0, m_busy = 1'b0;
  logic [15:0] m_l = 16'h0, m_r = 16'h0;

  int en_edge = -1, first_vld_edge = -1;
  int vld_total = 0, back2back = 0;
  bit prev_vld = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Full scale is 0x7FFF, zero ones is 0x8000, and everything between is linear.
  function automatic logic [15:0] conv_ref(input int k);
    int v;
    if (k == W) v = 32767;
    else        v = k * (65536 / W) - 32768;
    return v[15:0];
  endfunction

  // A pin value driven for edge n is counted at edge n+2.
  function automatic int win_sum(input int m, input bit left);
    int k = 0;
    for (int x = m - W + 1; x <= m; x++)
      k += left ? int'(pin_l[x-2]) : int'(pin_r[x-2]);
    return k;
  endfunction

  task automatic model_edge(input logic r, input logic e, input int m);
    int o;
    m_vld = 1'b0;
    if (r) begin
      m_active = 1'b0;
      m_l = 16'h0000;
      m_r = 16'h0000;
    end else if (!m_active) begin
      if (e) begin
        m_active = 1'b1;
        m_e0 = m;
      end
    end else if (!e) begin
      m_active = 1'b0;
    end else begin
      o = m - m_e0;
      if (o > W && ((o - W) % W) == 0) begin
        m_vld = 1'b1;
        m_l = conv_ref(win_sum(m, 1'b1));
        m_r = conv_ref(win_sum(m, 1'b0));
      end
    end
    m_busy = m_active;
  endtask

  // True when the next edge will be sampled with the window counter at c.
  function automatic bit run_cnt_is(input int c);
    return m_active && (cyc - m_e0) > W && ((cyc - m_e0 - W - 1) % W) == c;
  endfunction

  task automatic step(input logic r, input logic e, input logic l, input logic rr);
    rst = r; en = e; lft_PDM = l; rght_PDM = rr;
    pin_l[cyc] = l;
    pin_r[cyc] = rr;
    @(posedge clk);
    model_edge(r, e, cyc);
    #1;
    chk("vld", {31'b0, vld}, {31'b0, m_vld});
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
    chk("lft", {16'b0, lft_chnnl}, {16'b0, m_l});
    chk("rght", {16'b0, rght_chnnl}, {16'b0, m_r});
    if (vld === 1'b1) begin
      vld_total++;
      if (first_vld_edge < 0) first_vld_edge = cyc;
      if (prev_vld) back2back++;
    end
    prev_vld = (vld === 1'b1);
    cyc++;
    @(negedge clk);
  endtask

  // Left alternates 1/0 (mid-scale), right has one 1 every 4 clocks (quarter).
  task automatic step_pat(input logic e);
    step(1'b0, e, (cyc % 2) == 1, (cyc % 4) == 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int v0, b0;
    int unsigned dl, dr;
    int off_cnt;

    rst = 1'b1; en = 1'b0; lft_PDM = 1'b0; rght_PDM = 1'b0;
    @(negedge clk);

    // constant levels, first-sample latency
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_lft", {16'b0, lft_chnnl}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    en_edge = cyc;
    first_vld_edge = -1;
    for (int i = 0; i < 80; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("first_vld_latency", first_vld_edge - en_edge + 1, 33);
    chk("const_lft", {16'b0, lft_chnnl}, 32'h7FFF);
    chk("const_rght", {16'b0, rght_chnnl}, 32'h8000);

    // mid-scale / quarter-scale
    for (int i = 0; i < 64; i++) step_pat(1'b1);
    chk("mid_lft", {16'b0, lft_chnnl}, 32'h0000);
    chk("quarter_rght", {16'b0, rght_chnnl}, 32'hC000);

    // enable abort at window count 7
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (run_cnt_is(7)) found = 1'b1;
      else step_pat(1'b1);
    end
    chk("reach_cnt7", {31'b0, found}, 32'h1);
    step_pat(1'b0);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_vld", {31'b0, vld}, 32'h0);
    for (int i = 0; i < 20; i++) step_pat(1'b0);
    chk("abort_hold_lft", {16'b0, lft_chnnl}, 32'h0000);
    chk("abort_hold_rght", {16'b0, rght_chnnl}, 32'hC000);
    en_edge = cyc;
    first_vld_edge = -1;
    for (int i = 0; i < 40; i++) step_pat(1'b1);
    chk("reenable_latency", first_vld_edge - en_edge + 1, 33);

    // vld rate over 160 clocks of RUN
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (run_cnt_is(0)) found = 1'b1;
      else step_pat(1'b1);
    end
    chk("reach_cnt0", {31'b0, found}, 32'h1);
    v0 = vld_total;
    b0 = back2back;
    for (int i = 0; i < 160; i++)
      step(1'b0, 1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    chk("vld_count_160", vld_total - v0, 10);
    chk("vld_back2back", back2back - b0, 0);

    // reset at window count 15 suppresses the pending strobe
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (run_cnt_is(15)) found = 1'b1;
      else step(1'b0, 1'b1, 1'b1, 1'b1);
    end
    chk("reach_cnt15", {31'b0, found}, 32'h1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_vld", {31'b0, vld}, 32'h0);
    chk("rst_lft", {16'b0, lft_chnnl}, 32'h0000);
    chk("rst_rght", {16'b0, rght_chnnl}, 32'h0000);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_idle", {31'b0, busy}, 32'h0);

    // randomized densities, enable drops and occasional resets
    dl = 50; dr = 50; off_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 250) == 0) begin
        dl = $urandom_range(0, 100);
        dr = $urandom_range(0, 100);
      end
      if (off_cnt == 0 && $urandom_range(0, 299) == 0) off_cnt = $urandom_range(1, 20);
      step($urandom_range(0, 999) == 0, off_cnt == 0,
           $urandom_range(0, 99) < dl, $urandom_range(0, 99) < dr);
      if (off_cnt > 0) off_cnt--;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pdm_rcvr.md
Name: pdm_rcvr

Overview:
Receive side of the speaker PDM path. Takes a left and right 1-bit PDM stream, such as the spkr_drv outputs looped back or an external PDM source. Decimates each stream with a ones-counting boxcar window and emits 16-bit signed PCM samples with a one-cycle vld strobe, in the same format the EQ engine feeds to spkr_drv. Intended uses are loopback self-test of the PDM path and microphone/line capture.

Parameters:
DECIM_LOG2, 10, log2 of the decimation window length in clocks; legal range 1..15; window W = 2^DECIM_LOG2.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
en  input  1  receiver enable; level-sensitive.
lft_PDM  input  1  left PDM bit stream; may be asynchronous to clk.
rght_PDM  input  1  right PDM bit stream; may be asynchronous to clk.
vld  output  1  one-cycle strobe; lft_chnnl and rght_chnnl hold new samples.
lft_chnnl  output  16  signed left PCM sample.
rght_chnnl  output  16  signed right PCM sample.
busy  output  1  high when the FSM is in WARMUP or RUN.

Behaviour:
- Reset is synchronous and active-high: rst sampled high at posedge clk clears everything.
  - Synchronizer flops = 0.
  - State = IDLE, window counter = 0, both ones-accumulators = 0.
  - lft_chnnl = 16'h0000, rght_chnnl = 16'h0000, vld = 0, busy = 0.
- Synchronizer: each PDM input passes through 2 flops. Bit s is the second flop output, so a pin value is counted 2 clocks after capture.
- FSM states: IDLE, WARMUP, RUN.
  - IDLE: win_cnt and accumulators held at 0. en=1 -> WARMUP on the next clock.
  - WARMUP: runs one full window of W clocks with counting active. The window result is discarded and no vld is issued, which flushes the synchronizer and any partial data. At win_cnt == W-1 -> RUN, win_cnt -> 0, accumulators -> 0.
  - RUN: on every clock, win_cnt increments and acc += s, independently per channel.
  - RUN window end: on the edge after the cycle with win_cnt == W-1:
    - each output takes conv(acc + s), so the final bit of the window is included;
    - vld = 1 for exactly that one cycle;
    - accumulators -> 0 and win_cnt -> 0, so the next window starts with no gap;
    - the FSM stays in RUN.
  - en=0 in WARMUP or RUN -> IDLE on the next clock. The partial window is aborted, no vld is issued, and the outputs keep their last values.
- Window sizes: win_cnt is DECIM_LOG2 bits and wraps naturally. The accumulator is DECIM_LOG2+1 bits and holds k in 0..W.
- Conversion conv(k):
  - u = 16'hFFFF if k == W (saturate), else k << (16-DECIM_LOG2).
  - Output = u ^ 16'h8000, which converts unsigned to signed and mirrors the spkr_drv input conversion.
  - Result: k=0 -> 16'h8000, k=W/2 -> 16'h0000, k=W -> 16'h7FFF.
- Channel timing: left and right use the same window and the same vld, and update in the same cycle.
- Outputs hold between strobes. vld is registered, never combinational.
- Sample rate: in steady RUN, vld occurs every W clocks exactly.
- First sample latency: first vld = 2W+1 clocks after en is sampled high in IDLE (1 clock IDLE->WARMUP, W clocks WARMUP, W clocks RUN).
- busy = (state != IDLE), registered with the state.
- rst during any state or mid-window: all of the above reset values on the next edge. A vld pending that cycle is suppressed.

Test Plan (DECIM_LOG2=4, W=16, PDM pins driven synchronously to clk):
1. Constant levels: lft_PDM=1, rght_PDM=0, en=1 after reset -> first vld exactly 33 clocks after en sampled high, with lft_chnnl=16'h7FFF and rght_chnnl=16'h8000. Subsequent vld every 16 clocks with the same values.
2. Mid-scale and quarter-scale: left alternates 1/0 and right carries 4 ones per 16 clocks, all steady state -> lft_chnnl=16'h0000 and rght_chnnl=16'hC000 on every vld.
3. Loopback: spkr_drv fed constant lft_chnnl=16'h4000 and rght_chnnl=16'hC000, with its PDM outputs connected to this block (DECIM_LOG2=10) -> after settling, lft_chnnl within ±64 LSB of 16'h4000 and rght_chnnl within ±64 LSB of 16'hC000.
4. Enable abort: drop en at win_cnt=7 of a RUN window -> no vld for that window, busy=0 one clock later, outputs unchanged. Re-raise en -> next vld again 33 clocks later.
5. Reset mid-operation: assert rst for 1 clock at win_cnt=15 in RUN -> no vld in the following cycle, outputs=16'h0000, busy=0, state IDLE.
6. Per-clock pulse check: with en held high continuously, vld is never high on two consecutive clocks, and the count of vld pulses over 160 clocks of RUN is exactly 10.
